// File: rtl/nibble_add_scheduler_if.sv
// Request/grant/result bundle for nibble_add_scheduler.
//   master : drives req0/req1, a0/b0/cin0, a1/b1/cin1; observes grants and results
//   slave  : the scheduler; drives gnt0/gnt1, busy, sum, cout, done, done_id
interface nibble_add_scheduler_if;
   logic        req0;
   logic        req1;
   logic [15:0] a0;
   logic [15:0] b0;
   logic [15:0] a1;
   logic [15:0] b1;
   logic        cin0;
   logic        cin1;
   logic        gnt0;
   logic        gnt1;
   logic        busy;
   logic [15:0] sum;
   logic        cout;
   logic        done;
   logic        done_id;

   modport master (
      output req0, req1, a0, b0, a1, b1, cin0, cin1,
      input  gnt0, gnt1, busy, sum, cout, done, done_id
   );

   modport slave (
      input  req0, req1, a0, b0, a1, b1, cin0, cin1,
      output gnt0, gnt1, busy, sum, cout, done, done_id
   );
endinterface

// File: rtl/nibble_add_scheduler.sv
// Two-requester 16-bit adder built from one 4-bit ripple-carry slice reused
// over four cycles. Round-robin arbitration in IDLE, four ADD cycles
// (LSB nibble first), one DONE cycle that presents the result.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   bus     : slave side of nibble_add_scheduler_if
//             gnt0/gnt1 are combinational accept pulses (valid only in IDLE);
//             busy, sum, cout, done, done_id are registered.
module nibble_add_scheduler (
   input  logic                         clk,
   input  logic                         rst,
   nibble_add_scheduler_if.slave        bus
);

   localparam int unsigned DataW  = 16;
   localparam int unsigned NibW   = 4;
   localparam int unsigned NumNib = DataW / NibW;
   localparam int unsigned IdxW   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [IdxW-1:0]    idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [DataW-1:0]   acc_q, acc_d;
   logic [DataW-1:0]   opa_q, opa_d;
   logic [DataW-1:0]   opb_q, opb_d;
   logic               owner_q, owner_d;
   logic               last_id_q, last_id_d;
   logic [DataW-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               done_id_q, done_id_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic               gnt0_c, gnt1_c;
   logic [NibW-1:0]    nib_a_c, nib_b_c, nib_s_c;
   logic [NibW:0]      rc_c;
   logic               nib_co_c;

   // Single 4-bit ripple-carry slice over the current operand nibble.
   always_comb begin
      nib_a_c  = opa_q[{idx_q, 2'b00} +: NibW];
      nib_b_c  = opb_q[{idx_q, 2'b00} +: NibW];
      nib_s_c  = '0;
      rc_c     = '0;
      rc_c[0]  = carry_q;
      for (int i = 0; i < NibW; i++) begin
         nib_s_c[i]  = nib_a_c[i] ^ nib_b_c[i] ^ rc_c[i];
         rc_c[i+1]   = (nib_a_c[i] & nib_b_c[i]) | (rc_c[i] & (nib_a_c[i] ^ nib_b_c[i]));
      end
      nib_co_c = rc_c[NibW];
   end

   // Next-state, arbitration and datapath updates.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      acc_d     = acc_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      owner_d   = owner_q;
      last_id_d = last_id_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      done_id_d = done_id_q;
      gnt0_c    = 1'b0;
      gnt1_c    = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Round-robin: on contention the requester not served last wins.
            // Grants are gated by rst so nothing is accepted during reset.
            gnt0_c = ~rst & bus.req0 & (~bus.req1 |  last_id_q);
            gnt1_c = ~rst & bus.req1 & (~bus.req0 | ~last_id_q);
            if (gnt0_c || gnt1_c) begin
               opa_d   = gnt1_c ? bus.a1   : bus.a0;
               opb_d   = gnt1_c ? bus.b1   : bus.b0;
               carry_d = gnt1_c ? bus.cin1 : bus.cin0;
               owner_d = gnt1_c;
               idx_d   = '0;
               acc_d   = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            acc_d[{idx_q, 2'b00} +: NibW] = nib_s_c;
            carry_d = nib_co_c;
            idx_d   = idx_q + IdxW'(1);
            if (idx_q == IdxW'(NumNib - 1)) begin
               // Publish the completed word only here so partial sums stay hidden.
               sum_d     = acc_d;
               cout_d    = nib_co_c;
               done_id_d = owner_q;
               last_id_d = owner_q;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      done_d = (state_d == DONE);
      busy_d = (state_d != IDLE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         carry_q   <= 1'b0;
         acc_q     <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         owner_q   <= 1'b0;
         last_id_q <= 1'b1;
         sum_q     <= '0;
         cout_q    <= 1'b0;
         done_id_q <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         carry_q   <= carry_d;
         acc_q     <= acc_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         owner_q   <= owner_d;
         last_id_q <= last_id_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
         done_id_q <= done_id_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.gnt0    = gnt0_c;
   assign bus.gnt1    = gnt1_c;
   assign bus.busy    = busy_q;
   assign bus.sum     = sum_q;
   assign bus.cout    = cout_q;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;

endmodule

// File: tb/tb_nibble_add_scheduler.sv
// Directed bench for nibble_add_scheduler: reset values, single adds from
// each requester, carry boundaries, arbitration/pending behaviour, operand
// isolation after grant, and reset abort.
module tb_nibble_add_scheduler;

   logic clk;
   logic rst;

   nibble_add_scheduler_if bus();

   nibble_add_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int unsigned n_asserts = 0;
   int unsigned n_fail    = 0;

   logic [15:0] exp_sum;
   logic        exp_cout;
   logic        exp_id;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   // Called mid-cycle 0 (requests already driven). Checks the grant, the
   // four ADD cycles and the DONE cycle, then returns mid-cycle 6 (IDLE).
   task automatic add_seq(input bit id, input logic [15:0] es, input logic ec,
                          input bit hold, input bit raise_other);
      #1;
      chk1("gnt0_c0", bus.gnt0, ~id);
      chk1("gnt1_c0", bus.gnt1, id);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1 && !hold) begin
            if (id) begin bus.req1 = 1'b0; bus.a1 = ~bus.a1; end
            else    begin bus.req0 = 1'b0; bus.a0 = ~bus.a0; end
         end
         if (k == 2 && raise_other) begin
            if (id) bus.req0 = 1'b1;
            else    bus.req1 = 1'b1;
         end
         #1;
         chk1("gnt0_busy", bus.gnt0, 1'b0);
         chk1("gnt1_busy", bus.gnt1, 1'b0);
         chk1("busy", bus.busy, 1'b1);
         chk1("done", bus.done, (k == 5));
         if (k == 5) begin
            exp_sum  = es;
            exp_cout = ec;
            exp_id   = id;
         end
         chk16("sum", bus.sum, exp_sum);
         chk1("cout", bus.cout, exp_cout);
         chk1("done_id", bus.done_id, exp_id);
      end
      @(negedge clk);
      #1;
      chk1("busy_idle", bus.busy, 1'b0);
      chk1("done_idle", bus.done, 1'b0);
      chk16("sum_held", bus.sum, exp_sum);
   endtask

   initial begin
      exp_sum  = 16'h0000;
      exp_cout = 1'b0;
      exp_id   = 1'b0;
      rst      = 1'b1;
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      bus.a0   = 16'h0000; bus.b0 = 16'h0000; bus.cin0 = 1'b0;
      bus.a1   = 16'h0000; bus.b1 = 16'h0000; bus.cin1 = 1'b0;

      // Reset state, with both requests high.
      @(negedge clk);
      #1;
      chk1("rst_gnt0", bus.gnt0, 1'b0);
      chk1("rst_gnt1", bus.gnt1, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_done", bus.done, 1'b0);
      chk16("rst_sum", bus.sum, 16'h0000);
      chk1("rst_cout", bus.cout, 1'b0);
      chk1("rst_done_id", bus.done_id, 1'b0);
      @(negedge clk);
      rst      = 1'b0;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);

      // 0x1234 + 0x4321, a0 scribbled after grant.
      bus.a0 = 16'h1234; bus.b0 = 16'h4321; bus.cin0 = 1'b0; bus.req0 = 1'b1;
      add_seq(1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);

      // Carry ripples through all nibbles from requester 1.
      bus.a1 = 16'hFFFF; bus.b1 = 16'h0000; bus.cin1 = 1'b1; bus.req1 = 1'b1;
      add_seq(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);

      // MSB carry-out.
      bus.a0 = 16'h8000; bus.b0 = 16'h8000; bus.cin0 = 1'b0; bus.req0 = 1'b1;
      add_seq(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

      // Inter-nibble carries that stop short of cout.
      bus.a0 = 16'h0F0F; bus.b0 = 16'h00F1; bus.cin0 = 1'b0; bus.req0 = 1'b1;
      add_seq(1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

      // req1 raised during ADD stays pending, then is granted in IDLE.
      bus.a0 = 16'h0001; bus.b0 = 16'h0002; bus.cin0 = 1'b1; bus.req0 = 1'b1;
      bus.a1 = 16'h1111; bus.b1 = 16'h2222; bus.cin1 = 1'b0;
      add_seq(1'b0, 16'h0004, 1'b0, 1'b0, 1'b1);
      add_seq(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);

      // Both requests held from reset: alternating grants every 6 cycles.
      rst      = 1'b1;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      bus.a0 = 16'h00FF; bus.b0 = 16'h0001; bus.cin0 = 1'b0;
      bus.a1 = 16'hABCD; bus.b1 = 16'h1111; bus.cin1 = 1'b1;
      exp_sum = 16'h0000; exp_cout = 1'b0; exp_id = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      add_seq(1'b0, 16'h0100, 1'b0, 1'b1, 1'b0);
      add_seq(1'b1, 16'hBCDF, 1'b0, 1'b1, 1'b0);
      add_seq(1'b0, 16'h0100, 1'b0, 1'b1, 1'b0);

      // Reset during ADD idx=2 aborts the add from requester 1.
      #1;
      chk1("abort_gnt1", bus.gnt1, 1'b1);
      chk1("abort_gnt0", bus.gnt0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      exp_sum = 16'h0000; exp_cout = 1'b0; exp_id = 1'b0;
      chk1("abort_busy", bus.busy, 1'b0);
      chk1("abort_done", bus.done, 1'b0);
      chk16("abort_sum", bus.sum, 16'h0000);
      chk1("abort_cout", bus.cout, 1'b0);
      chk1("abort_done_id", bus.done_id, 1'b0);
      chk1("abort_gnt1_rst", bus.gnt1, 1'b0);
      @(negedge clk);
      #1;
      chk1("abort_done_hold", bus.done, 1'b0);
      rst = 1'b0;
      // First grant after reset goes to requester 0.
      add_seq(1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/nibble_add_scheduler.md
NIBBLE_ADD_SCHEDULER -- requirements
Module: nibble_add_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the port list SHALL be as follows.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 req0 / req1  in  1  add request from requester 0 / 1; held high until granted.
REQ-005 a0, b0 / a1, b1  in  16  operands of requester 0 / 1; valid while reqN is high.
REQ-006 cin0 / cin1  in  1  carry-in of requester 0 / 1.
REQ-007 gnt0 / gnt1  out  1  combinational one-cycle accept pulse; operands are captured on the same rising edge.
REQ-008 busy  out  1  high from the cycle after a grant through the done cycle.
REQ-009 sum  out  16  registered result of the last completed add.
REQ-010 cout  out  1  registered carry-out of the last completed add.
REQ-011 done  out  1  one-cycle pulse; sum, cout and done_id are valid in this cycle.
REQ-012 done_id  out  1  index of the requester whose result is on sum.

Function
REQ-013 The adder datapath SHALL be a single 4-bit ripple-carry slice reused over four cycles, with no wider adder.
REQ-014 The FSM SHALL have exactly three states: IDLE, ADD, DONE.
REQ-015 IDLE: gnt0 = req0 & (~req1 | last_id==1); gnt1 = req1 & (~req0 | last_id==0); at most one grant is high.
REQ-016 On a grant edge the block SHALL capture a, b and cin of the granted requester, set nibble index to 0, record the owner, and enter ADD.
REQ-017 ADD: each cycle SHALL add operand nibble[idx] plus the carry register, store the 4-bit result in the internal accumulator, and update the carry register.
REQ-018 ADD SHALL last exactly 4 cycles (idx 0..3, LSB nibble first), then enter DONE.
REQ-019 On entry to DONE, sum SHALL take the full accumulator value, cout SHALL take the final carry, done_id SHALL take the owner, and last_id SHALL take the owner.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE; no grant is issued in DONE.
REQ-021 Latency: grant in cycle T puts done high in cycle T+5; peak throughput is one add per 6 cycles.
REQ-022 Requests seen in ADD or DONE SHALL be ignored (gnt stays 0) and remain pending until IDLE.
REQ-023 sum, cout and done_id SHALL hold their value between done pulses; partial results are never visible on sum.
REQ-024 Arithmetic: {cout,sum} = a + b + cin modulo 2^17, exact for all 16-bit inputs.
REQ-025 Operand changes after the grant edge SHALL NOT affect the result in progress.

Reset
REQ-026 While rst=1: state=IDLE, idx=0, carry=0, accumulator=0, sum=0, cout=0, done=0, done_id=0, busy=0, last_id=1, and gnt0=gnt1=0.
REQ-027 A reset asserted mid-operation SHALL abort the add with no done pulse; the first grant after reset goes to req0 if req0 is high.

Verification
REQ-028 req0=1, a0=0x1234, b0=0x4321, cin0=0 -> gnt0 in cycle 0, busy in cycles 1-5, done in cycle 5 with sum=0x5555, cout=0, done_id=0.
REQ-029 req1 only, a1=0xFFFF, b1=0x0000, cin1=1 -> sum=0x0000, cout=1, done_id=1 (carry ripples through all nibbles).
REQ-030 a0=0x8000, b0=0x8000, cin0=0 -> sum=0x0000, cout=1; a0=0x0F0F, b0=0x00F1, cin0=0 -> sum=0x1000, cout=0.
REQ-031 req0 and req1 held high from reset -> grants alternate gnt0, gnt1, gnt0, ... at 6-cycle spacing, and done_id alternates 0, 1, 0.
REQ-032 req1 raised during ADD of a req0 add -> gnt1 stays 0 until IDLE, then asserts; a0 changed after gnt0 -> result unchanged.
REQ-033 rst pulsed at ADD idx=2 -> all outputs 0 asynchronously, no done; with both reqs high afterwards, gnt0 is granted first.
